ifu_prefetch: RTL and testbench

- Parametrised next-generation instruction fetch unit: Wishbone B4 classic master that keeps fetching sequential words ahead of decode into a DEPTH-entry prefetch FIFO.
- Does not stall on every control-flow opcode: fetches past branches speculatively, flushes on taken jump/branch (je).
- Sits between the instruction bus and decode; delivers {instruction, pc, pc+4} with a valid flag; injects NOP when empty or flushing.

---
 rtl/ifu_prefetch_if.sv | 30 +++
 rtl/ifu_prefetch.sv | 165 ++++++++++++++++
 tb/tb_ifu_prefetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// -----------------------------------------------------------------------------
// wishbone : Wishbone B4 classic bus bundle used by the instruction fetch unit.
//
//   ADR   [XLEN-1:0]  byte address, master -> slave
//   DAT_R [31:0]      read data, slave -> master
//   DAT_W [31:0]      write data, master -> slave
//   SEL   [3:0]       byte lane selects, master -> slave
//   WE                write enable, master -> slave
//   STB, CYC          strobe / cycle, master -> slave
//   ACK               transfer acknowledge, slave -> master
//
// Handshake: a transfer is requested while STB=CYC=1 and completes on the
// rising clock edge at which ACK=1; the master keeps STB/CYC asserted until
// that edge. An ACK seen while STB=0 carries no transfer.
// -----------------------------------------------------------------------------
interface wishbone #(
   parameter int XLEN = 32
) ();
   logic [XLEN-1:0] ADR;
   logic [31:0]     DAT_R;
   logic [31:0]     DAT_W;
   logic [3:0]      SEL;
   logic            WE;
   logic            STB;
   logic            CYC;
   logic            ACK;

   modport MASTER (output ADR, DAT_W, SEL, WE, STB, CYC, input DAT_R, ACK);
   modport SLAVE  (input ADR, DAT_W, SEL, WE, STB, CYC, output DAT_R, ACK);
endinterface

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch : instruction fetch unit with a DEPTH-entry prefetch FIFO.
//
// Fetches sequential 32-bit words ahead of decode over a Wishbone classic
// master port and keeps fetching past branches; a taken jump (je) flushes the
// FIFO and redirects fetch to ja. A request already on the bus when je hits
// is completed and its data discarded (DRAIN).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   instr_bus     wishbone.MASTER fetch port
//   stall         decode not accepting, head entry held
//   je, ja        taken jump and its (word aligned) target
//   instr_valid   head entry presented
//   instr_out     head instruction, NOP (addi x0,x0,0) when empty or stalled
//   curr_pc       PC of the head entry (fetch PC while empty)
//   inc_pc        curr_pc + 4
//   stalled       !instr_valid
//   fsm_state     fetch FSM state, for debug and assertions
//
// Optional: define IFU_PREFETCH_STATS_EN to add fetch_cnt, flush_cnt and
// discard_cnt event counters.
// -----------------------------------------------------------------------------
module ifu_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   wishbone.MASTER         instr_bus,
   input  logic            stall,
   input  logic            je,
   input  logic [XLEN-1:0] ja,
   output logic            instr_valid,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] curr_pc,
   output logic [XLEN-1:0] inc_pc,
   output logic            stalled,
`ifdef IFU_PREFETCH_STATS_EN
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     flush_cnt,
   output logic [31:0]     discard_cnt,
`endif
   output logic [1:0]      fsm_state
);

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  FETCH = 2'd1;
   localparam logic [1:0]  DRAIN = 2'd2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          AW    = $clog2(DEPTH);
   localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

   logic [31:0]     fifo_instr [DEPTH];
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW:0]     count, count_next;
   logic [1:0]      state, state_next;
   logic [XLEN-1:0] fetch_pc, fetch_pc_next;
   logic [XLEN-1:0] ja_aligned;
   logic            ack, push, pop, space_ok;

   assign ack        = instr_bus.ACK;
   assign ja_aligned = ja & ~XLEN'(3);

   // A jump kills both the head pop and any data arriving in the same cycle.
   assign push       = (state == FETCH) && ack && !je;
   assign pop        = instr_valid && !stall && !je;
   assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);

   // A full FIFO may still issue when the head leaves this cycle, so the
   // single outstanding request always has a slot when it completes.
   assign space_ok   = (count < FULL) || pop;

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      case (state)
         IDLE: begin
            if (je) begin
               fetch_pc_next = ja_aligned;
               state_next    = FETCH;
            end else if (space_ok) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (je) begin
               fetch_pc_next = ja_aligned;
               // Request completing now is simply dropped; otherwise wait it out.
               state_next    = ack ? FETCH : DRAIN;
            end else if (ack) begin
               fetch_pc_next = fetch_pc + XLEN'(4);
               state_next    = (count_next < FULL) ? FETCH : IDLE;
            end
         end
         DRAIN: begin
            if (je) fetch_pc_next = ja_aligned;
            if (ack) state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         if (je) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            count <= count_next;
         end
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= instr_bus.DAT_R;
         fifo_pc[wr_ptr]    <= fetch_pc;
      end
   end

   assign instr_valid = (count != '0);
   assign stalled     = !instr_valid;
   assign instr_out   = (instr_valid && !stall) ? fifo_instr[rd_ptr] : NOP;
   assign curr_pc     = instr_valid ? fifo_pc[rd_ptr] : fetch_pc;
   assign inc_pc      = curr_pc + XLEN'(4);
   assign fsm_state   = state;

   assign instr_bus.ADR   = fetch_pc;
   assign instr_bus.DAT_W = '0;
   assign instr_bus.SEL   = 4'b1111;
   assign instr_bus.WE    = 1'b0;
   assign instr_bus.STB   = (state == FETCH) || (state == DRAIN);
   assign instr_bus.CYC   = (state == FETCH) || (state == DRAIN);

`ifdef IFU_PREFETCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt   <= '0;
         flush_cnt   <= '0;
         discard_cnt <= '0;
      end else begin
         if (push) fetch_cnt <= fetch_cnt + 32'd1;
         if (je)   flush_cnt <= flush_cnt + 32'd1;
         if (ack && (((state == FETCH) && je) || (state == DRAIN)))
            discard_cnt <= discard_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_prefetch : bench for ifu_prefetch. A memory slave with programmable
// wait states answers fetches; a reference model of the delivered instruction
// stream (sequential words from the reset PC or the last jump target) feeds an
// expected queue that the monitor compares against the decode-side outputs.
// -----------------------------------------------------------------------------
module tb_ifu_prefetch;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        stall, je, late_ack;
   logic [31:0] ja;
   logic        instr_valid, stalled;
   logic [31:0] instr_out, curr_pc, inc_pc;
   logic [1:0]  fsm_state;
`ifdef IFU_PREFETCH_STATS_EN
   logic [31:0] fetch_cnt, flush_cnt, discard_cnt;
`endif

   wishbone #(.XLEN(XLEN)) bus ();

   ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_bus   (bus),
      .stall       (stall),
      .je          (je),
      .ja          (ja),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .curr_pc     (curr_pc),
      .inc_pc      (inc_pc),
      .stalled     (stalled),
`ifdef IFU_PREFETCH_STATS_EN
      .fetch_cnt   (fetch_cnt),
      .flush_cnt   (flush_cnt),
      .discard_cnt (discard_cnt),
`endif
      .fsm_state   (fsm_state)
   );

   // ---------------- memory slave ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   int ws;
   int wcnt;
   assign bus.ACK   = (bus.STB && (wcnt >= ws)) || late_ack;
   assign bus.DAT_R = mem_word(bus.ADR);

   always @(posedge clk or posedge rst) begin
      if (rst)                       wcnt <= 0;
      else if (bus.STB && !bus.ACK)  wcnt <= wcnt + 1;
      else                           wcnt <= 0;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [63:0] exp_q[$];        // {pc, instr} of words the DUT should hold
   logic [31:0] m_fetch_pc;      // address the next request must use
   bit          m_stale;         // outstanding request was overtaken by a jump
   int          push_cnt, m_flush, m_discard, deliveries;
   logic [63:0] head;
   logic [31:0] exp_inc;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_fetch_pc = RESET_PC;
         m_stale    = 0;
         push_cnt   = 0;
         m_flush    = 0;
         m_discard  = 0;
      end else begin
`ifdef IFU_PREFETCH_STATS_EN
         chk("fetch_cnt", fetch_cnt, push_cnt);
         chk("flush_cnt", flush_cnt, m_flush);
         chk("discard_cnt", discard_cnt, m_discard);
`endif
         chk("instr_valid", instr_valid, exp_q.size() != 0);
         chk("stalled", stalled, exp_q.size() == 0);
         chk("cyc_eq_stb", bus.CYC, bus.STB);
         chk("sel_we_datw", {bus.SEL, bus.WE, bus.DAT_W}, {4'hF, 1'b0, 32'h0});
         if (bus.STB) chk("adr", bus.ADR, m_fetch_pc);
         if (exp_q.size() != 0) begin
            head    = exp_q[0];
            exp_inc = head[63:32] + 32'd4;
            chk("curr_pc", curr_pc, head[63:32]);
            chk("inc_pc", inc_pc, exp_inc);
            chk("instr_out", instr_out, stall ? NOP : head[31:0]);
         end else begin
            chk("instr_out_nop", instr_out, NOP);
         end
         if (exp_q.size() != 0 && !stall && !je) begin
            void'(exp_q.pop_front());
            deliveries++;
         end
         if (je) begin
            m_flush++;
            exp_q.delete();
            m_fetch_pc = ja;
            if (bus.STB && bus.ACK) begin
               m_discard++;
               m_stale = 0;
            end else if (bus.STB) begin
               m_stale = 1;
            end
         end else if (bus.STB && bus.ACK) begin
            if (m_stale) begin
               m_stale = 0;
               m_discard++;
            end else begin
               exp_q.push_back({m_fetch_pc, mem_word(m_fetch_pc)});
               m_fetch_pc = m_fetch_pc + 32'd4;
               push_cnt++;
            end
         end
         chk("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic st);
      @(posedge clk); #1;
      rst = 1'b1; stall = st; je = 1'b0; late_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic jump(input logic [31:0] target);
      je = 1'b1; ja = target;
      cycles(1);
      je = 1'b0;
   endtask

   task automatic report;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // ---------------- stimulus ----------------
   int          d0;
   bit          found;
   logic [31:0] exp_rst_inc;

   initial begin
      rst = 1'b1; stall = 1'b0; je = 1'b0; ja = '0; ws = 0; late_ack = 1'b0;
      deliveries = 0;
      cycles(2);
      exp_rst_inc = RESET_PC + 32'd4;
      chk("rst_stb", bus.STB, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_curr_pc", curr_pc, RESET_PC);
      chk("rst_inc_pc", inc_pc, exp_rst_inc);
      chk("rst_stalled", stalled, 1'b1);
      rst = 1'b0;

      // first valid word two edges after reset release, then one per cycle
      cycles(1);
      chk("lat1_valid", instr_valid, 1'b0);
      cycles(1);
      chk("lat2_valid", instr_valid, 1'b1);
      chk("lat2_pc", curr_pc, RESET_PC);
      d0 = deliveries;
      cycles(8);
      chk("throughput", deliveries - d0, 8);

      // stall from reset: fill exactly DEPTH entries, then the bus goes idle
      do_reset(1'b1);
      cycles(10);
      chk("stall_pushes", push_cnt, DEPTH);
      chk("stall_stb", bus.STB, 1'b0);
      chk("stall_nop", instr_out, NOP);
      stall = 1'b0;
      cycles(10);

      // jump on the second cycle of a 3-wait request -> drain, then ja
      ws = 3;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycles(1);
         if (bus.STB && wcnt == 1) found = 1;
      end
      chk("drain_setup", found, 1'b1);
      jump(32'h100);
      chk("drain_flush", instr_valid, 1'b0);
      cycles(20);

      // jump coincident with ACK and pop, zero-wait slave
      ws = 0;
      cycles(5);
      jump(32'h40);
      chk("ackje_flush", instr_valid, 1'b0);
      chk("ackje_adr", bus.ADR, 32'h40);
      chk("ackje_stb", bus.STB, 1'b1);
      cycles(1);
      chk("ackje_valid", instr_valid, 1'b1);
      chk("ackje_pc", curr_pc, 32'h40);
      cycles(5);

      // reset in the middle of a bus cycle with three words buffered
      ws = 2;
      do_reset(1'b1);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycles(1);
         if (exp_q.size() == 3 && bus.STB) found = 1;
      end
      chk("midrst_setup", found, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_stb", bus.STB, 1'b0);
      chk("midrst_cyc", bus.CYC, 1'b0);
      chk("midrst_valid", instr_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; late_ack = 1'b1; stall = 1'b0;
      cycles(1);
      late_ack = 1'b0;
      cycles(10);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) ws = $urandom_range(0, 3);
         stall = ($urandom_range(0, 3) == 0);
         je    = ($urandom_range(0, 15) == 0);
         ja    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                             : 32'($urandom_range(0, 1023)) << 2;
         cycles(1);
      end
      je = 1'b0; stall = 1'b0;
      cycles(20);
      report();
   end

   initial begin
      #500000;
      total++;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      report();
   end
endmodule
